// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
//   Shared definitions for the SIPO deserializer slice:
//     - sipo_state_e : output-register FSM encoding (COLLECT / HOLD)
//     - cnt_width()  : width of the bit-position counter for a given WIDTH
//   The counter must be able to hold WIDTH itself (the parity position when
//   the optional parity bit is enabled), hence clog2(WIDTH+1).
// ---------------------------------------------------------------------------
package sipo_pkg;

  // COLLECT: no word held on the output. HOLD: pout_valid is asserted.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } sipo_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// ---------------------------------------------------------------------------
// sipo_bit_counter
//   Bit-position counter for the deserializer. Counts 0..LAST and wraps.
//   Ports:
//     clk    in  1  clock, rising edge
//     clr    in  1  synchronous active-high reset, dominates everything
//     en     in  1  advance by one (one serial bit captured this cycle)
//     align  in  1  restart the count; with en the restarting bit is bit 0,
//                   so the counter lands on 1 instead of 0
//     tc     out 1  terminal count: the current bit is the last of a word
// ---------------------------------------------------------------------------
module sipo_bit_counter #(
  parameter int CW   = 3,
  parameter int LAST = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic align,
  output logic tc
);

  localparam logic [CW-1:0] LAST_C = CW'(LAST);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == LAST_C);

  // Align takes priority over the terminal-count wrap, so a realign on the
  // last bit position never produces a completed word.
  always_comb begin
    cnt_d = cnt_q;
    if (align) begin
      cnt_d = en ? ONE_C : '0;
    end else if (en) begin
      cnt_d = tc ? '0 : (cnt_q + ONE_C);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in / parallel-out stage. Collects WIDTH serial bits into a word and
//   presents it on a registered output with a valid/ready handshake. Bit
//   capture never stalls; only the output register is back-pressured, and a
//   word completed while the held word is not being accepted is dropped and
//   recorded in the sticky overrun flag.
//
//   Optional feature macro: SIPO_PARITY_CHECK_EN
//     defined   : each word is WIDTH data bits plus one trailing even-parity
//                 bit (not stored in pout); parity_err is loaded with pout.
//     undefined : words are WIDTH bits; parity_err is tied to 0.
//
//   Parameters:
//     WIDTH      data bits per word (>= 2)
//     MSB_FIRST  1: first received bit lands in pout[WIDTH-1]
//                0: first received bit lands in pout[0]
//   Ports:
//     clk         in  1      clock, rising edge
//     clr         in  1      synchronous active-high reset
//     sin         in  1      serial data, sampled when shift_en=1
//     shift_en    in  1      one bit is presented on sin this cycle
//     align       in  1      discard partial word, restart bit count
//     pout        out WIDTH  assembled word, stable while pout_valid=1
//     pout_valid  out 1      word available
//     pout_ready  in  1      consumer accepts when pout_valid && pout_ready
//     overrun     out 1      sticky: a completed word was dropped
//     parity_err  out 1      parity mismatch on the current pout
// ---------------------------------------------------------------------------
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             align,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_CHECK_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  sipo_state_e      state_q;
  sipo_state_e      state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] pout_q;
  logic [WIDTH-1:0] pout_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             cnt_tc;
  logic             word_done;
  logic             data_bit;
  logic             load_word;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] word;

  sipo_bit_counter #(
    .CW   (CW),
    .LAST (LAST)
  ) u_bit_counter (
    .clk   (clk),
    .clr   (clr),
    .en    (shift_en),
    .align (align),
    .tc    (cnt_tc)
  );

  // A word completes on the last bit position, unless a realign arrives on
  // the same edge.
  assign word_done = shift_en && cnt_tc && !align;

`ifdef SIPO_PARITY_CHECK_EN
  // The trailing parity bit is consumed by the checker, not shifted in, so
  // the completed data word is whatever the shift register already holds.
  assign data_bit = !cnt_tc;
  assign word     = sr_q;
`else
  // The last data bit is presented on the completing edge itself, so the
  // word taken into pout is the shift register including that bit.
  assign data_bit = 1'b1;
  assign word     = sr_shifted;
`endif

  // Shift path. Realign clears the register first so a bit presented on
  // the same edge becomes the first bit of a fresh word.
  always_comb begin
    sr_base = align ? '0 : sr_q;
    if (MSB_FIRST) begin
      sr_shifted = {sr_base[WIDTH-2:0], sin};
    end else begin
      sr_shifted = {sin, sr_base[WIDTH-1:1]};
    end

    sr_d = sr_q;
    if (align) begin
      sr_d = shift_en ? sr_shifted : '0;
    end else if (shift_en && data_bit) begin
      sr_d = sr_shifted;
    end
  end

  // Output FSM. A completion while HOLD is being accepted replaces the word
  // with no idle cycle; a completion while HOLD is stalled is dropped.
  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    load_word = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (word_done) begin
          load_word = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (word_done) begin
          if (pout_ready) begin
            load_word = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (pout_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
    pout_d = load_word ? word : pout_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_COLLECT;
      sr_q      <= '0;
      pout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pout_q    <= pout_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic parity_err_q;
  logic parity_err_d;
  logic word_perr;

  // Even parity: data bits XOR parity bit must be 0. The flag travels with
  // pout, so a dropped word leaves it untouched.
  always_comb begin
    word_perr    = (^sr_q) ^ sin;
    parity_err_d = load_word ? word_perr : parity_err_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign pout       = pout_q;
  assign pout_valid = (state_q == ST_HOLD);
  assign overrun    = overrun_q;

endmodule
